// File: rtl/hlsm_launcher.sv
// Initiator for the HLSM Start/Done handshake: accepts one operand triple, launches
// the HLSM, waits for Done with a bounded timeout and presents the result.
module hlsm_launcher #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_c,
  output logic          hlsm_start,
  output logic [DW-1:0] hlsm_a,
  output logic [DW-1:0] hlsm_b,
  output logic [DW-1:0] hlsm_c,
  input  logic          hlsm_done,
  input  logic [DW-1:0] hlsm_z,
  input  logic [DW-1:0] hlsm_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_z,
  output logic [DW-1:0] out_x,
  output logic          out_timeout,
  output logic          stray_done
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DW-1:0] z_q, z_d, x_q, x_d;
  logic          to_q, to_d;
  logic          stray_q, stray_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= '0;
      x_q     <= '0;
      to_q    <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
      x_q     <= x_d;
      to_q    <= to_d;
      stray_q <= stray_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;
    x_d     = x_q;
    to_d    = to_q;
    // Done outside WAIT never touches data or state, it is only recorded.
    stray_d = stray_q | (hlsm_done && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          c_d     = in_c;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over the timeout on the final WAIT cycle.
        if (hlsm_done) begin
          z_d     = hlsm_z;
          x_d     = hlsm_x;
          to_d    = 1'b0;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          z_d     = '0;
          x_d     = '0;
          to_d    = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign hlsm_start  = (state_q == S_LAUNCH);
  assign out_valid   = (state_q == S_HOLD);
  assign hlsm_a      = a_q;
  assign hlsm_b      = b_q;
  assign hlsm_c      = c_q;
  assign out_z       = z_q;
  assign out_x       = x_q;
  assign out_timeout = to_q;
  assign stray_done  = stray_q;

endmodule

// File: tb/tb_hlsm_launcher.sv
// Directed bench for hlsm_launcher; the HLSM side is mocked by driving Done/z/x by hand.
module tb_hlsm_launcher;

  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic          hlsm_start;
  logic [DW-1:0] hlsm_a, hlsm_b, hlsm_c;
  logic          hlsm_done = 1'b0;
  logic [DW-1:0] hlsm_z = '0, hlsm_x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_z, out_x;
  logic          out_timeout;
  logic          stray_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  hlsm_launcher #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .hlsm_start(hlsm_start), .hlsm_a(hlsm_a), .hlsm_b(hlsm_b), .hlsm_c(hlsm_c),
    .hlsm_done(hlsm_done), .hlsm_z(hlsm_z), .hlsm_x(hlsm_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_x(out_x), .out_timeout(out_timeout),
    .stray_done(stray_done)
  );

  always #5 Clk = ~Clk;

  // Advance one clock; everything after returns is sampled 1ns past the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the LAUNCH cycle.
  task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    in_valid = 1'b1; in_a = a; in_b = b; in_c = c;
    step();
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(); step();
    Rst = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (hlsm_start !== 1'b0) $display("FAIL reset_start: got %b expected 0", hlsm_start); else pass_cnt++;
    total_cnt++; if ({hlsm_a, hlsm_b, hlsm_c} !== '0) $display("FAIL reset_operands: got %h %h %h expected 0 0 0", hlsm_a, hlsm_b, hlsm_c); else pass_cnt++;
    total_cnt++; if ({out_valid, out_timeout, stray_done} !== 3'b000) $display("FAIL reset_flags: got valid=%b to=%b stray=%b expected 0 0 0", out_valid, out_timeout, stray_done); else pass_cnt++;
    total_cnt++; if ({out_z, out_x} !== '0) $display("FAIL reset_results: got %h %h expected 0 0", out_z, out_x); else pass_cnt++;
    $display("txn reset done");
  endtask

  task automatic test_basic();
    int extra_start = 0;
    int early_valid = 0;
    launch(32'd5, 32'd3, 32'd2);
    total_cnt++; if (hlsm_start !== 1'b1) $display("FAIL basic_start: got %b expected 1", hlsm_start); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_launch: got %b expected 0", in_ready); else pass_cnt++;
    total_cnt++; if ({hlsm_a, hlsm_b, hlsm_c} !== {32'd5, 32'd3, 32'd2}) $display("FAIL basic_operands: got %0d %0d %0d expected 5 3 2", hlsm_a, hlsm_b, hlsm_c); else pass_cnt++;
    // Start cycle is S; done comes at S+6.
    for (int i = 1; i <= 6; i++) begin
      step();
      if (hlsm_start !== 1'b0) extra_start++;
      if (out_valid !== 1'b0) early_valid++;
    end
    hlsm_done = 1'b1; hlsm_z = 32'd7; hlsm_x = 32'd16;
    step();
    hlsm_done = 1'b0;
    total_cnt++; if (extra_start != 0) $display("FAIL basic_start_width: got %0d extra start cycles expected 0", extra_start); else pass_cnt++;
    total_cnt++; if (early_valid != 0) $display("FAIL basic_early_valid: got %0d early cycles expected 0", early_valid); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if ({out_z, out_x, out_timeout} !== {32'd7, 32'd16, 1'b0}) $display("FAIL basic_result: got z=%0d x=%0d to=%b expected 7 16 0", out_z, out_x, out_timeout); else pass_cnt++;
    total_cnt++; if ({hlsm_a, hlsm_b, hlsm_c} !== {32'd5, 32'd3, 32'd2}) $display("FAIL basic_operands_hold: got %0d %0d %0d expected 5 3 2", hlsm_a, hlsm_b, hlsm_c); else pass_cnt++;
    release_result();
    total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid); else pass_cnt++;
    $display("txn basic z=%0d x=%0d", out_z, out_x);
  endtask

  task automatic test_back_to_back();
    int unstable = 0;
    launch(-32'sd4, 32'd9, 32'd1);
    step();
    hlsm_done = 1'b1; hlsm_z = 32'd123; hlsm_x = -32'sd5;
    step();
    hlsm_done = 1'b0;
    // Second request waits at the port during the stalled HOLD.
    in_valid = 1'b1; in_a = 32'd11; in_b = 32'd12; in_c = 32'd13;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, in_ready, out_timeout} !== 3'b100) unstable++;
      if ({out_z, out_x} !== {32'd123, -32'sd5}) unstable++;
      if (hlsm_a !== -32'sd4) unstable++;
      step();
    end
    total_cnt++; if (unstable != 0) $display("FAIL bp_stable: got %0d unstable samples expected 0", unstable); else pass_cnt++;
    release_result();
    total_cnt++; if ({in_ready, hlsm_start} !== 2'b10) $display("FAIL bp_after_release: got ready=%b start=%b expected 1 0", in_ready, hlsm_start); else pass_cnt++;
    total_cnt++; if (hlsm_a !== -32'sd4) $display("FAIL bp_no_early_accept: got a=%h expected fffffffc", hlsm_a); else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++; if ({hlsm_start, hlsm_a, hlsm_b, hlsm_c} !== {1'b1, 32'd11, 32'd12, 32'd13}) $display("FAIL bp_second_launch: got start=%b %0d %0d %0d expected 1 11 12 13", hlsm_start, hlsm_a, hlsm_b, hlsm_c); else pass_cnt++;
    step();
    hlsm_done = 1'b1; hlsm_z = 32'd1; hlsm_x = 32'd2;
    step();
    hlsm_done = 1'b0;
    total_cnt++; if ({out_valid, out_z, out_x} !== {1'b1, 32'd1, 32'd2}) $display("FAIL bp_second_result: got valid=%b z=%0d x=%0d expected 1 1 2", out_valid, out_z, out_x); else pass_cnt++;
    release_result();
    $display("txn back_to_back z=%0d x=%0d", out_z, out_x);
  endtask

  task automatic test_timeout();
    int early_valid = 0;
    launch(32'd1, 32'd2, 32'd3);
    step();  // first WAIT cycle
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      if (out_valid !== 1'b0) early_valid++;
    end
    total_cnt++; if (early_valid != 0) $display("FAIL to_early_valid: got %0d early cycles expected 0", early_valid); else pass_cnt++;
    step();  // WAIT entry + TIMEOUT
    total_cnt++; if ({out_valid, out_timeout} !== 2'b11) $display("FAIL to_flags: got valid=%b to=%b expected 1 1", out_valid, out_timeout); else pass_cnt++;
    total_cnt++; if ({out_z, out_x} !== '0) $display("FAIL to_zero_results: got z=%h x=%h expected 0 0", out_z, out_x); else pass_cnt++;
    release_result();
    $display("txn timeout to=1");
    launch(32'd7, 32'd8, 32'd9);
    step();
    hlsm_done = 1'b1; hlsm_z = 32'd100; hlsm_x = 32'd200;
    step();
    hlsm_done = 1'b0;
    total_cnt++; if ({out_valid, out_timeout, out_z, out_x} !== {2'b10, 32'd100, 32'd200}) $display("FAIL to_recovery: got valid=%b to=%b z=%0d x=%0d expected 1 0 100 200", out_valid, out_timeout, out_z, out_x); else pass_cnt++;
    release_result();
    $display("txn after_timeout z=%0d x=%0d", out_z, out_x);
  endtask

  task automatic test_done_last();
    launch(32'd4, 32'd4, 32'd4);
    step();  // counter 0
    for (int i = 1; i < TIMEOUT; i++) step();  // counter TIMEOUT-1
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL last_not_yet: got valid=%b expected 0", out_valid); else pass_cnt++;
    hlsm_done = 1'b1; hlsm_z = 32'hFFFF_FFFF; hlsm_x = 32'h8000_0000;
    step();
    hlsm_done = 1'b0;
    total_cnt++; if ({out_valid, out_timeout} !== 2'b10) $display("FAIL last_flags: got valid=%b to=%b expected 1 0", out_valid, out_timeout); else pass_cnt++;
    total_cnt++; if ({out_z, out_x} !== {32'hFFFF_FFFF, 32'h8000_0000}) $display("FAIL last_results: got z=%h x=%h expected ffffffff 80000000", out_z, out_x); else pass_cnt++;
    release_result();
    total_cnt++; if (stray_done !== 1'b0) $display("FAIL no_stray_yet: got %b expected 0", stray_done); else pass_cnt++;
    $display("txn done_last z=%h", out_z);
  endtask

  task automatic test_stray();
    hlsm_done = 1'b1; hlsm_z = 32'd55; hlsm_x = 32'd66;
    step();
    hlsm_done = 1'b0;
    total_cnt++; if (stray_done !== 1'b1) $display("FAIL stray_idle_set: got %b expected 1", stray_done); else pass_cnt++;
    total_cnt++; if ({in_ready, out_valid, out_z} !== {2'b10, 32'hFFFF_FFFF}) $display("FAIL stray_idle_ignored: got ready=%b valid=%b z=%h expected 1 0 ffffffff", in_ready, out_valid, out_z); else pass_cnt++;
    launch(32'd1, 32'd1, 32'd1);
    step();
    hlsm_done = 1'b1; hlsm_z = 32'd3; hlsm_x = 32'd4;
    step();
    hlsm_z = 32'd99; hlsm_x = 32'd98;  // done stays high into HOLD
    step();
    hlsm_done = 1'b0;
    total_cnt++; if ({out_valid, out_z, out_x, stray_done} !== {1'b1, 32'd3, 32'd4, 1'b1}) $display("FAIL stray_hold_ignored: got valid=%b z=%0d x=%0d stray=%b expected 1 3 4 1", out_valid, out_z, out_x, stray_done); else pass_cnt++;
    release_result();
    step();
    total_cnt++; if (stray_done !== 1'b1) $display("FAIL stray_sticky: got %b expected 1", stray_done); else pass_cnt++;
    $display("txn stray z=%0d x=%0d", out_z, out_x);
  endtask

  task automatic test_reset_mid_wait();
    int bad_valid = 0;
    launch(32'd2, 32'd2, 32'd2);  // Start cycle S
    step(); step(); step();        // S+3
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    total_cnt++; if ({in_ready, out_valid, hlsm_start, out_timeout, stray_done} !== 5'b10000) $display("FAIL rst_flags: got ready=%b valid=%b start=%b to=%b stray=%b expected 1 0 0 0 0", in_ready, out_valid, hlsm_start, out_timeout, stray_done); else pass_cnt++;
    total_cnt++; if ({hlsm_a, hlsm_b, hlsm_c, out_z, out_x} !== '0) $display("FAIL rst_data: got a=%h z=%h x=%h expected 0 0 0", hlsm_a, out_z, out_x); else pass_cnt++;
    step();
    hlsm_done = 1'b1; hlsm_z = 32'd77; hlsm_x = 32'd88;
    step();
    hlsm_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) bad_valid++;
      step();
    end
    total_cnt++; if (bad_valid != 0) $display("FAIL rst_no_result: got %0d valid cycles expected 0", bad_valid); else pass_cnt++;
    total_cnt++; if ({stray_done, in_ready, out_z} !== {2'b11, 32'd0}) $display("FAIL rst_late_done: got stray=%b ready=%b z=%0d expected 1 1 0", stray_done, in_ready, out_z); else pass_cnt++;
    $display("txn reset_mid_wait stray=%b", stray_done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_done_last();
    test_stray();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
